// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and oversampling constants shared by the UART receive
// and transmit paths.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned MID_SAMPLE_DEF = OVERSAMPLE_DEF / 2;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE   = 3'd0;
  localparam rx_state_t RX_START  = 3'd1;
  localparam rx_state_t RX_DATA   = 3'd2;
  localparam rx_state_t RX_PARITY = 3'd3;
  localparam rx_state_t RX_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: write port from the UART receiver into the RX FIFO.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_w_en;
  logic [DATA_WIDTH-1:0] fifo_w_data;
  logic                  fifo_full;

  modport master (output fifo_w_en, output fifo_w_data, input fifo_full);
  modport slave  (input fifo_w_en, input fifo_w_data, output fifo_full);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator; down-counter reloaded from div on
// load or on underflow, tick asserted while the count is zero.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - DIV_WIDTH'(1);
    if (load || (cnt_q == '0)) cnt_d = div;
  end

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8051 UART receive front end; 16x oversampled 8N1 decode feeding the RX FIFO.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd in, parity_err out).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rxd,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  uart_rx_if.master            fifo,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int MID_SAMPLE = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  logic                  sync1_q, sync2_q, prev_q;
  logic                  start_edge, tick, load, mid_hit, bit_hit;
  rx_state_t             state_q, state_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, w_data_q, w_data_d;
  logic                  w_en_q, w_en_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit_q, par_bit_d, par_err_q, par_err_d, par_ok;
  assign par_ok     = ((^shift_q) ^ par_bit_q) == parity_odd;
  assign parity_err = par_err_q;
`endif

  // Two sync flops plus an edge flop; a start bit is a synced 1 -> 0 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start_edge = prev_q & ~sync2_q;
  assign load       = (state_q == RX_IDLE) && start_edge && rx_en;
  assign mid_hit    = tick && (tick_cnt_q == TW'(MID_SAMPLE - 1));
  assign bit_hit    = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .div  (baud_div),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    w_data_d    = w_data_q;
    w_en_d      = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d   = par_bit_q;
    par_err_d   = 1'b0;
`endif
    if (tick) tick_cnt_d = tick_cnt_q + TW'(1);
    case (state_q)
      RX_IDLE: begin
        tick_cnt_d = '0;
        if (start_edge) state_d = RX_START;
      end
      RX_START: if (mid_hit) begin
        // Recheck the line at mid start bit to reject glitches.
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_hit) begin
        tick_cnt_d = '0;
        shift_d    = {sync2_q, shift_q[DATA_WIDTH-1:1]};
        bit_cnt_d  = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = RX_PARITY;
`else
          state_d = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (bit_hit) begin
        tick_cnt_d = '0;
        par_bit_d  = sync2_q;
        state_d    = RX_STOP;
      end
`endif
      RX_STOP: if (bit_hit) begin
        tick_cnt_d = '0;
        state_d    = RX_IDLE;
        if (!sync2_q) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        else if (!par_ok) par_err_d = 1'b1;
`endif
        else if (fifo.fifo_full) overrun_d = 1'b1;
        else begin
          w_en_d   = 1'b1;
          w_data_d = shift_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // Disabling the receiver abandons any partial frame silently.
    if (!rx_en) begin
      state_d     = RX_IDLE;
      w_en_d      = 1'b0;
      w_data_d    = w_data_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      w_data_q    <= '0;
      w_en_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      w_data_q    <= w_data_d;
      w_en_q      <= w_en_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= par_bit_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign fifo.fifo_w_en   = w_en_q;
  assign fifo.fifo_w_data = w_data_q;
  assign frame_err        = frame_err_q;
  assign overrun_err      = overrun_q;
  assign busy             = (state_q != RX_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level reference model of the UART receiver; directed cases plus
// randomized frames, each outcome and its timing window compared against the DUT.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst, rx_en, rxd;
  logic [15:0] baud_div;
  logic        frame_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_odd, parity_err, par_bit;
`endif

  uart_rx_if #(.DATA_WIDTH(DW)) fifo_if ();

  uart_rx #(.DATA_WIDTH(DW), .DIV_WIDTH(16), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_en       (rx_en),
    .baud_div    (baud_div),
    .rxd         (rxd),
`ifdef UART_RX_PARITY_EN
    .parity_odd  (parity_odd),
    .parity_err  (parity_err),
`endif
    .fifo        (fifo_if),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int          bitlen;
  logic [7:0]  last_wr;

  // Event kinds: 1 write, 2 frame error, 3 overrun, 4 parity error.
  int          exp_kind[$];
  int          exp_data[$];
  int unsigned exp_lo[$];
  int          act_kind[$];
  int          act_data[$];
  int unsigned act_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int   mon_n;
  int   mon_k;
  logic prev_any = 1'b0;
  always @(negedge clk) begin
    mon_n = int'(fifo_if.fifo_w_en) + int'(frame_err) + int'(overrun_err);
`ifdef UART_RX_PARITY_EN
    mon_n += int'(parity_err);
`endif
    if (mon_n != 0 && !rst) begin
      chk("one_flag", mon_n, 1);
      chk("pulse_width", prev_any, 0);
      mon_k = fifo_if.fifo_w_en ? 1 : frame_err ? 2 : overrun_err ? 3 : 4;
      act_kind.push_back(mon_k);
      act_data.push_back(int'(fifo_if.fifo_w_data));
      act_cyc.push_back(cyc);
    end
    prev_any = (mon_n != 0);
  end

  task automatic set_div(input int d);
    baud_div = 16'(d);
    bitlen   = OS * (d + 1);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (bitlen) @(negedge clk);
  endtask

  // Predicts the outcome of one frame from its bit values, then drives it.
  task automatic send_frame(input logic [7:0] data, input logic stop_v, input int gap);
    int   kind;
    logic ok_par;
    ok_par = 1'b1;
`ifdef UART_RX_PARITY_EN
    ok_par = (((^data) ^ par_bit) == parity_odd);
`endif
    if (!rx_en)                 kind = 0;
    else if (!stop_v)           kind = 2;
    else if (!ok_par)           kind = 4;
    else if (fifo_if.fifo_full) kind = 3;
    else                        kind = 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(data[i]);
      if (i == 0 && rx_en) chk("busy_mid", busy, 1);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    if (kind != 0) begin
      exp_kind.push_back(kind);
      exp_data.push_back(int'(data));
      exp_lo.push_back(cyc + bitlen / 2);
      if (kind == 1) last_wr = data;
    end
    drive_bit(stop_v);
    for (int g = 0; g < gap; g++) drive_bit(1'b1);
    rxd = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (busy && budget < 20 * bitlen) begin
      @(negedge clk);
      budget++;
    end
    if (busy) chk({tag, "_timeout"}, 1, 0);
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, act_kind.size(), exp_kind.size());
    for (int i = 0; i < exp_kind.size() && i < act_kind.size(); i++) begin
      chk({tag, "_kind"}, act_kind[i], exp_kind[i]);
      if (exp_kind[i] == 1) chk({tag, "_data"}, act_data[i], exp_data[i]);
      chk({tag, "_latency"}, (act_cyc[i] >= exp_lo[i]) && (act_cyc[i] <= exp_lo[i] + 8), 1);
    end
    chk({tag, "_hold"}, fifo_if.fifo_w_data, last_wr);
    exp_kind.delete(); exp_data.delete(); exp_lo.delete();
    act_kind.delete(); act_data.delete(); act_cyc.delete();
  endtask

  initial begin
    rst = 1'b1; rx_en = 1'b1; rxd = 1'b1; fifo_if.fifo_full = 1'b0;
    last_wr = 8'h00;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0; par_bit = 1'b0;
`endif
    set_div(0);
    repeat (3) @(negedge clk);
    chk("rst_w_en", fifo_if.fifo_w_en, 0);
    chk("rst_w_data", fifo_if.fifo_w_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    par_bit = ^8'hA5;
`endif
    send_frame(8'hA5, 1'b1, 1);
    drain("t1");

    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    drain("t2_glitch");
    chk("t2_busy", busy, 0);

`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h3C;
`endif
    send_frame(8'h3C, 1'b0, 1);
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h12;
`endif
    send_frame(8'h12, 1'b1, 1);
    drain("t3_frame");

    fifo_if.fifo_full = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h55;
`endif
    send_frame(8'h55, 1'b1, 1);
    fifo_if.fifo_full = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h66;
`endif
    send_frame(8'h66, 1'b1, 1);
    drain("t4_overrun");

    set_div(3);
`ifdef UART_RX_PARITY_EN
    par_bit = 1'b0;
`endif
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1);
    drain("t5_b2b");

    set_div(0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0);
    rxd = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    rst = 1'b0;
    last_wr = 8'h00;
    repeat (12 * bitlen) @(negedge clk);
    drain("t6_abort");
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h81;
`endif
    send_frame(8'h81, 1'b1, 1);
    drain("t6_resend");

    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("en_busy", busy, 1);
    rx_en = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    chk("en_drop_busy", busy, 0);
    repeat (12 * bitlen) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1);
    rx_en = 1'b1;
    @(negedge clk);
    drain("en_off");
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'hC3;
`endif
    send_frame(8'hC3, 1'b1, 1);
    drain("en_back");

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    par_bit = 1'b0;
    send_frame(8'h07, 1'b1, 1);
    par_bit = 1'b1;
    send_frame(8'h07, 1'b1, 1);
    drain("t7_parity");
`endif

    for (int d = 0; d < 3; d++) begin
      logic [7:0] data;
      logic       stop_v;
      int         gap;
      set_div(d);
      for (int f = 0; f < 5; f++) begin
        data   = 8'($urandom);
        stop_v = ($urandom_range(0, 4) != 0);
        gap    = stop_v ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
        fifo_if.fifo_full = ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
        par_bit = 1'($urandom);
        parity_odd = 1'($urandom);
`endif
        send_frame(data, stop_v, gap);
      end
      fifo_if.fifo_full = 1'b0;
      drain("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
